// File: rtl/guess_pkg.sv
// Shared types and constants for the Bulls-and-Cows guess entry datapath.
package guess_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [3:0] digit_t;

  localparam digit_t KEY_DEL   = 4'hA;
  localparam digit_t KEY_ENTER = 4'hB;
  localparam digit_t KEY_CLR   = 4'hC;

  typedef enum logic [1:0] {
    S_ENTRY,
    S_FULL,
    S_SUBMIT
  } state_t;

endpackage

// File: rtl/guess_entry_if.sv
// Key strobe input and guess valid/ready handshake towards the scorer.
interface guess_entry_if;
  import guess_pkg::*;

  logic   key_valid;
  digit_t key_code;
  logic   guess_valid;
  logic   guess_ready;
  digit_t Guess [NUM_DIGITS-1:0];

  modport master (
    output key_valid, key_code, guess_ready,
    input  guess_valid, Guess
  );

  modport slave (
    input  key_valid, key_code, guess_ready,
    output guess_valid, Guess
  );
endinterface

// File: rtl/guess_entry_dup_check.sv
// Flags a candidate digit that already sits in one of the occupied guess slots.
module digit_dup_check
  import guess_pkg::*;
(
  input  digit_t     slots [NUM_DIGITS-1:0],
  input  logic [2:0] entry_count,
  input  digit_t     cand,
  output logic       dup
);

  // Slots fill from the top, so slot i is occupied once i + entry_count reaches NUM_DIGITS.
  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((i + 32'(entry_count)) >= NUM_DIGITS && slots[2'(i)] == cand)
        dup = 1'b1;
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Keypad guess collector: edits a 4-digit guess, hands it to the scorer, counts attempts.
module guess_entry
  import guess_pkg::*;
#(
  parameter bit ALLOW_REPEAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         game_restart,
  guess_entry_if.slave gif,
  output logic [2:0]   entry_count,
  output logic         key_reject,
  output logic [3:0]   attempt_count
);

  state_t     state;
  digit_t     slots [NUM_DIGITS-1:0];
  logic       guess_valid_q;
  logic       dup;
  logic       is_digit;
  logic       digit_ok;
  logic [1:0] wr_idx;
  logic [1:0] del_idx;

  digit_dup_check u_dup (
    .slots       (slots),
    .entry_count (entry_count),
    .cand        (gif.key_code),
    .dup         (dup)
  );

  // First digit lands in slot 3; the most recent digit is at slot 4-entry_count.
  assign wr_idx   = ~entry_count[1:0];
  assign del_idx  = 2'(3'd4 - entry_count);
  assign is_digit = (gif.key_code <= 4'd9);
  assign digit_ok = ALLOW_REPEAT || !dup;

  assign gif.guess_valid = guess_valid_q;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_guess
    assign gif.Guess[i] = slots[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || game_restart) begin
      state         <= S_ENTRY;
      slots         <= '{default: '0};
      entry_count   <= '0;
      attempt_count <= '0;
      guess_valid_q <= 1'b0;
      key_reject    <= 1'b0;
    end else begin
      key_reject <= 1'b0;
      case (state)
        S_SUBMIT: begin
          if (guess_valid_q && gif.guess_ready) begin
            state         <= S_ENTRY;
            slots         <= '{default: '0};
            entry_count   <= '0;
            guess_valid_q <= 1'b0;
            if (attempt_count != 4'hF)
              attempt_count <= attempt_count + 4'd1;
          end
        end
        default: begin
          if (gif.key_valid) begin
            if (is_digit) begin
              if (state == S_FULL || !digit_ok) begin
                key_reject <= 1'b1;
              end else begin
                slots[wr_idx] <= gif.key_code;
                entry_count   <= entry_count + 3'd1;
                if (entry_count == 3'd3)
                  state <= S_FULL;
              end
            end else begin
              case (gif.key_code)
                KEY_ENTER: begin
                  if (state == S_FULL) begin
                    state         <= S_SUBMIT;
                    guess_valid_q <= 1'b1;
                  end else begin
                    key_reject <= 1'b1;
                  end
                end
                KEY_DEL: begin
                  if (entry_count != 3'd0) begin
                    slots[del_idx] <= '0;
                    entry_count    <= entry_count - 3'd1;
                    state          <= S_ENTRY;
                  end
                end
                KEY_CLR: begin
                  slots       <= '{default: '0};
                  entry_count <= '0;
                  state       <= S_ENTRY;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Drives two guess_entry instances (repeats rejected / allowed) against a list-based model.
module tb_guess_entry;
  import guess_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n        = 1'b0;
  logic       game_restart = 1'b0;
  logic       kv           = 1'b0;
  logic [3:0] kc           = 4'h0;
  logic       rdy          = 1'b0;

  guess_entry_if gi0 ();
  guess_entry_if gi1 ();

  assign gi0.key_valid   = kv;
  assign gi0.key_code    = kc;
  assign gi0.guess_ready = rdy;
  assign gi1.key_valid   = kv;
  assign gi1.key_code    = kc;
  assign gi1.guess_ready = rdy;

  logic [2:0] ec0, ec1;
  logic       kr0, kr1;
  logic [3:0] ac0, ac1;

  guess_entry #(.ALLOW_REPEAT(1'b0)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .game_restart  (game_restart),
    .gif           (gi0.slave),
    .entry_count   (ec0),
    .key_reject    (kr0),
    .attempt_count (ac0)
  );

  guess_entry #(.ALLOW_REPEAT(1'b1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .game_restart  (game_restart),
    .gif           (gi1.slave),
    .entry_count   (ec1),
    .key_reject    (kr1),
    .attempt_count (ac1)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model per instance: entered digits in entry order, a waiting flag, attempts, reject pulse.
  int md   [2][4];
  int mn   [2];
  bit msub [2];
  int matt [2];
  bit mrej [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear(input int k);
    mn[k]   = 0;
    msub[k] = 1'b0;
  endfunction

  function automatic void model_step(input int k);
    bit present;
    mrej[k] = 1'b0;
    if (!rst_n || game_restart) begin
      model_clear(k);
      matt[k] = 0;
    end else if (msub[k]) begin
      if (rdy) begin
        model_clear(k);
        if (matt[k] < 15) matt[k]++;
      end
    end else if (kv) begin
      if (kc <= 4'd9) begin
        present = 1'b0;
        for (int j = 0; j < mn[k]; j++)
          if (md[k][j] == int'(kc)) present = 1'b1;
        if (mn[k] == 4 || (k == 0 && present)) mrej[k] = 1'b1;
        else begin
          md[k][mn[k]] = int'(kc);
          mn[k]++;
        end
      end else if (kc == KEY_ENTER) begin
        if (mn[k] == 4) msub[k] = 1'b1;
        else mrej[k] = 1'b1;
      end else if (kc == KEY_DEL) begin
        if (mn[k] > 0) mn[k]--;
      end else if (kc == KEY_CLR) begin
        mn[k] = 0;
      end
    end
  endfunction

  function automatic int exp_slot(input int k, input int idx);
    int pos = 3 - idx;
    return (pos < mn[k]) ? md[k][pos] : 0;
  endfunction

  task automatic compare_inst(input int k, input logic gv, input logic [2:0] ec, input logic kr,
                              input logic [3:0] ac, input logic [15:0] g);
    check($sformatf("u%0d.guess_valid", k), 32'(gv), 32'(msub[k]));
    check($sformatf("u%0d.entry_count", k), 32'(ec), 32'(mn[k]));
    check($sformatf("u%0d.key_reject", k), 32'(kr), 32'(mrej[k]));
    check($sformatf("u%0d.attempt_count", k), 32'(ac), 32'(matt[k]));
    for (int i = 0; i < 4; i++)
      check($sformatf("u%0d.Guess[%0d]", k, i), 32'(g[i*4 +: 4]), 32'(exp_slot(k, i)));
  endtask

  function automatic logic [15:0] pack0();
    return {gi0.Guess[3], gi0.Guess[2], gi0.Guess[1], gi0.Guess[0]};
  endfunction

  function automatic logic [15:0] pack1();
    return {gi1.Guess[3], gi1.Guess[2], gi1.Guess[1], gi1.Guess[0]};
  endfunction

  task automatic step(input logic k_v, input logic [3:0] k_c, input logic r,
                      input logic gr, input logic rn);
    @(negedge clk);
    kv = k_v; kc = k_c; rdy = r; game_restart = gr; rst_n = rn;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_inst(0, gi0.guess_valid, ec0, kr0, ac0, pack0());
    compare_inst(1, gi1.guess_valid, ec1, kr1, ac1, pack1());
  endtask

  task automatic key(input logic [3:0] c, input logic r);
    step(1'b1, c, r, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, r, 1'b0, 1'b1);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic r);
    key(a, r); key(b, r); key(c, r); key(d, r); key(KEY_ENTER, r);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      model_clear(k); matt[k] = 0; mrej[k] = 1'b0;
    end

    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("reset_attempt", 32'(ac0), 32'd0);

    // Basic submission with scorer ready.
    enter4(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    check("submit_guess", 32'(pack0()), 32'h1234);
    idle(2, 1'b1);
    check("submit_attempt", 32'(ac0), 32'd1);

    // Repeated digit: rejected on u0, accepted on u1.
    key(4'd5, 1'b0); key(4'd5, 1'b0);
    check("dup_reject", 32'(kr0), 32'd1);
    check("dup_allowed_count", 32'(ec1), 32'd2);
    key(KEY_CLR, 1'b0);

    // Edit with DEL, reject digit while full and ENTER while partial.
    key(4'd1, 1'b0); key(4'd2, 1'b0); key(KEY_ENTER, 1'b0);
    key(4'd3, 1'b0); key(4'd4, 1'b0); key(KEY_DEL, 1'b0); key(4'd9, 1'b0);
    key(4'd7, 1'b0);
    check("full_reject", 32'(kr0), 32'd1);
    key(KEY_ENTER, 1'b0);
    check("edited_guess", 32'(pack0()), 32'h1239);
    key(4'd8, 1'b0); key(KEY_CLR, 1'b0); idle(3, 1'b0);
    check("wait_guess", 32'(pack0()), 32'h1239);
    idle(2, 1'b1);

    // Saturate attempts, then restart coincident with a transfer.
    for (int n = 0; n < 16; n++) begin
      enter4(4'd0, 4'd1, 4'd2, 4'd3, 1'b1);
      idle(1, 1'b1);
    end
    check("attempt_sat", 32'(ac0), 32'd15);
    enter4(4'd6, 4'd7, 4'd8, 4'd9, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    check("restart_attempt", 32'(ac0), 32'd0);

    // Reset while guess is waiting.
    enter4(4'd4, 4'd3, 4'd2, 4'd1, 1'b1);
    idle(1, 1'b1);
    enter4(4'd9, 4'd8, 4'd7, 4'd6, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", 32'(gi0.guess_valid), 32'd0);
    idle(1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      step(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 96) == 0), 1'($urandom_range(0, 150) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
